// File: rtl/mult8x8_seq_core.sv
// ============================================================================
//  mult8x8_seq_core
//  Sequential 8x8 unsigned multiplier: four 4x4 partial products, one per clock,
//  accumulated with shifts. The FSM code drives a seven-segment display controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mult8x8_seq_core (
   input  logic        clk,
   input  logic        reset_a,
   input  logic        start,
   input  logic [7:0]  dataa,
   input  logic [7:0]  datab,
   output logic [15:0] product8x8_out,
   output logic        done_flag,
   output logic [2:0]  state_out
);

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      LSB       = 3'b001,
      MID       = 3'b010,
      MSB       = 3'b011,
      CALC_DONE = 3'b100,
      ERR       = 3'b101
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [7:0]  a_r;
   logic [7:0]  b_r;
   logic [15:0] acc;
   logic [1:0]  cnt;

   logic [3:0]  sel_a;
   logic [3:0]  sel_b;
   logic [3:0]  shift;
   logic [7:0]  pp;
   logic [15:0] term;

   logic        capture;
   logic        busy;
   logic        step_ok;

   // The state register is the display code itself, so state_out is registered.
   assign state_out = state;

   assign capture = start && ((state == IDLE) || (state == CALC_DONE));
   assign busy    = (state == LSB) || (state == MID) || (state == MSB);
   assign step_ok = busy && !start;

   // Partial-product selection keyed on the step counter.
   always_comb begin
      sel_a = a_r[3:0];
      sel_b = b_r[3:0];
      shift = 4'd0;
      case (cnt)
         2'd0: begin
            sel_a = a_r[3:0];
            sel_b = b_r[3:0];
            shift = 4'd0;
         end
         2'd1: begin
            sel_a = a_r[3:0];
            sel_b = b_r[7:4];
            shift = 4'd4;
         end
         2'd2: begin
            sel_a = a_r[7:4];
            sel_b = b_r[3:0];
            shift = 4'd4;
         end
         default: begin
            sel_a = a_r[7:4];
            sel_b = b_r[7:4];
            shift = 4'd8;
         end
      endcase
      pp   = {4'd0, sel_a} * {4'd0, sel_b};
      term = {8'd0, pp} << shift;
   end

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = LSB;
         end
         LSB: begin
            state_nxt = start ? ERR : MID;
         end
         MID: begin
            if (start)            state_nxt = ERR;
            else if (cnt == 2'd1) state_nxt = MID;
            else                  state_nxt = MSB;
         end
         MSB: begin
            state_nxt = start ? ERR : CALC_DONE;
         end
         CALC_DONE: begin
            state_nxt = start ? LSB : IDLE;
         end
         ERR: begin
            state_nxt = start ? ERR : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: an aborted operation leaves product8x8_out untouched.
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         a_r            <= 8'd0;
         b_r            <= 8'd0;
         acc            <= 16'd0;
         cnt            <= 2'd0;
         product8x8_out <= 16'd0;
         done_flag      <= 1'b0;
      end else begin
         done_flag <= 1'b0;
         if (capture) begin
            a_r <= dataa;
            b_r <= datab;
            acc <= 16'd0;
            cnt <= 2'd0;
         end else if (step_ok) begin
            acc <= acc + term;
            cnt <= cnt + 2'd1;
            if (state == MSB) begin
               product8x8_out <= acc + term;
               done_flag      <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mult8x8_seq_core.sv
// ============================================================================
//  tb_mult8x8_seq_core
//  Directed scoreboard bench for the sequential 8x8 multiplier.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult8x8_seq_core;

   logic        clk;
   logic        reset_a;
   logic        start;
   logic [7:0]  dataa;
   logic [7:0]  datab;
   logic [15:0] product8x8_out;
   logic        done_flag;
   logic [2:0]  state_out;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   mult8x8_seq_core dut (
      .clk            (clk),
      .reset_a        (reset_a),
      .start          (start),
      .dataa          (dataa),
      .datab          (datab),
      .product8x8_out (product8x8_out),
      .done_flag      (done_flag),
      .state_out      (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for done_flag after the LSB cycle; pops and checks the product.
   task automatic wait_done(input string tag, input bit scramble);
      int n;
      n = 0;
      do begin
         if (scramble) begin
            dataa = 8'($urandom);
            datab = 8'($urandom);
         end
         step();
         n++;
      end while (!done_flag && n < 10);
      chk({tag, "_latency"}, n, 4);
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
      else                   chk({tag, "_product"}, product8x8_out, exp_q.pop_front());
   endtask

   // Launch one operation from IDLE; returns with the DUT in CALC_DONE.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit scramble);
      dataa = a;
      datab = b;
      start = 1'b1;
      exp_q.push_back(16'(a) * 16'(b));
      step();
      start = 1'b0;
      chk({tag, "_lsb"}, state_out, 3'b001);
      wait_done(tag, scramble);
   endtask

   initial begin
      int dones;
      reset_a = 1'b0;
      start   = 1'b0;
      dataa   = 8'd0;
      datab   = 8'd0;
      step();
      step();
      chk("rst_state", state_out, 3'b000);
      chk("rst_product", product8x8_out, 16'h0000);
      chk("rst_done", done_flag, 1'b0);
      reset_a = 1'b1;
      step();
      chk("idle_state", state_out, 3'b000);

      // Normal operation with cycle-exact state sequence.
      dataa = 8'h12;
      datab = 8'h34;
      start = 1'b1;
      exp_q.push_back(16'h03A8);
      step();
      start = 1'b0;
      chk("n_e1", state_out, 3'b001);
      step();
      chk("n_e2", state_out, 3'b010);
      chk("n_e2_done", done_flag, 1'b0);
      step();
      chk("n_e3", state_out, 3'b010);
      step();
      chk("n_e4", state_out, 3'b011);
      chk("n_e4_done", done_flag, 1'b0);
      step();
      chk("n_e5", state_out, 3'b100);
      chk("n_e5_done", done_flag, 1'b1);
      chk("n_product", product8x8_out, exp_q.pop_front());
      step();
      chk("n_e6", state_out, 3'b000);
      chk("n_e6_done", done_flag, 1'b0);
      chk("n_hold", product8x8_out, 16'h03A8);

      // Boundary operands.
      do_op("max", 8'hFF, 8'hFF, 1'b0);
      chk("max_lit", product8x8_out, 16'hFE01);
      step();
      do_op("zero", 8'h00, 8'hA5, 1'b0);
      step();
      do_op("pow", 8'h10, 8'h10, 1'b0);
      chk("pow_lit", product8x8_out, 16'h0100);
      step();

      // Error path: start raised during MID.
      do_op("pre_err", 8'h03, 8'h05, 1'b0);
      step();
      dataa = 8'h0F;
      datab = 8'h0F;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("e_mid", state_out, 3'b010);
      start = 1'b1;
      step();
      chk("e_err", state_out, 3'b101);
      chk("e_err_done", done_flag, 1'b0);
      step();
      chk("e_err_hold", state_out, 3'b101);
      chk("e_prod_hold", product8x8_out, 16'h000F);
      chk("e_done_hold", done_flag, 1'b0);
      start = 1'b0;
      step();
      chk("e_idle", state_out, 3'b000);
      chk("e_prod_after", product8x8_out, 16'h000F);
      chk("e_done_after", done_flag, 1'b0);

      // Back-to-back: start held in CALC_DONE.
      do_op("b2b_first", 8'h21, 8'h02, 1'b0);
      chk("b2b_done_state", state_out, 3'b100);
      dataa = 8'h07;
      datab = 8'h09;
      start = 1'b1;
      exp_q.push_back(16'h003F);
      step();
      start = 1'b0;
      chk("b2b_direct", state_out, 3'b001);
      chk("b2b_done_clr", done_flag, 1'b0);
      wait_done("b2b_second", 1'b0);
      step();

      // Operand changes after capture must not matter.
      do_op("stab", 8'h9C, 8'h3B, 1'b1);
      chk("stab_lit", product8x8_out, 16'h23F4);
      step();

      // Asynchronous reset in MID, then no done_flag afterwards.
      dataa = 8'hAB;
      datab = 8'hCD;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("r_mid", state_out, 3'b010);
      #2;
      reset_a = 1'b0;
      #1;
      chk("r_async_state", state_out, 3'b000);
      chk("r_async_product", product8x8_out, 16'h0000);
      chk("r_async_done", done_flag, 1'b0);
      step();
      reset_a = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done_flag) dones++;
      end
      chk("r_no_done", dones, 0);
      chk("r_idle", state_out, 3'b000);
      chk("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
